// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between the byte-stream requesters, the arbiter and the
// uart_top write port.
//   req_valid/req_data/req_last/req_ready : per-requester byte handshake
//   wr_en/d_in/tx_full                     : uart_top TX write port
//   grant/busy                             : arbitration status
// slave  = arbiter view, master = requester/UART side view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;   // requester i at bits [i*DATA_W +: DATA_W]
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           wr_en;
  logic [DATA_W-1:0]              d_in;
  logic                           tx_full;
  logic [NUM_REQ-1:0]             grant;
  logic                           busy;

  modport slave (
    input  req_valid, req_data, req_last, tx_full,
    output req_ready, wr_en, d_in, grant, busy
  );

  modport master (
    output req_valid, req_data, req_last, tx_full,
    input  req_ready, wr_en, d_in, grant, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the uart_top TX write port among NUM_REQ
// byte-stream requesters. A granted requester keeps the port until it
// sends a byte flagged last or has sent MAX_BURST bytes, then the pointer
// moves one past it. One idle cycle separates consecutive bursts.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : uart_tx_arbiter_if.slave (requester handshake, UART port, status)

// Per-requester gating: only the granted lane can see ready, write or
// drive data onto the shared byte bus.
module uart_tx_arb_lane #(
  parameter int DATA_W = 8
) (
  input  logic              sel,
  input  logic              tx_full,
  input  logic              valid,
  input  logic              last,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              wr,
  output logic              wr_last,
  output logic [DATA_W-1:0] data_m
);
  assign ready   = sel & ~tx_full;
  assign wr      = ready & valid;
  assign wr_last = wr & last;
  assign data_m  = sel ? data : '0;
endmodule

module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                   state_q, state_d;
  logic [NUM_REQ-1:0]       grant_q, grant_d;
  logic [PTR_W-1:0]         owner_q, owner_d;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [7:0]               burst_cnt_q, burst_cnt_d;

  logic [NUM_REQ-1:0]             lane_ready, lane_wr, lane_wr_last;
  logic [NUM_REQ-1:0][DATA_W-1:0] lane_data;
  logic                           xfer, xfer_last;
  logic                           pick_found;
  logic [PTR_W-1:0]               pick_idx;

  // grant_q is all-zero in IDLE, so every lane is gated off there
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    uart_tx_arb_lane #(.DATA_W(DATA_W)) u_lane (
      .sel     (grant_q[gi]),
      .tx_full (bus.tx_full),
      .valid   (bus.req_valid[gi]),
      .last    (bus.req_last[gi]),
      .data    (bus.req_data[gi]),
      .ready   (lane_ready[gi]),
      .wr      (lane_wr[gi]),
      .wr_last (lane_wr_last[gi]),
      .data_m  (lane_data[gi])
    );
  end

  assign xfer      = |lane_wr;
  assign xfer_last = |lane_wr_last;

  // First valid requester scanning from rr_ptr upward with wrap
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && bus.req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = BURST;
          grant_d     = '0;
          grant_d[pick_idx] = 1'b1;
          owner_d     = pick_idx;
          burst_cnt_d = '0;
        end
      end
      BURST: begin
        if (xfer) begin
          // last byte and burst cap in the same cycle collapse to one exit
          if (xfer_last || burst_cnt_q == 8'(MAX_BURST - 1)) begin
            state_d     = IDLE;
            grant_d     = '0;
            burst_cnt_d = '0;
            rr_ptr_d    = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          end else begin
            burst_cnt_d = burst_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Outputs: purely from registered state/grant plus live inputs, so the
  // asynchronous reset clears them without waiting for a clock edge
  always_comb begin
    bus.req_ready = lane_ready;
    bus.wr_en     = xfer;
    bus.grant     = grant_q;
    bus.busy      = (state_q == BURST);
    bus.d_in      = '0;
    for (int i = 0; i < NUM_REQ; i++) bus.d_in = bus.d_in | lane_data[i];
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_val(input int i, input int s);
    return 8'((i << 6) | (s & 63));
  endfunction

  // ---------------- behavioural model ----------------
  // owner = -1 when nobody holds the port
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  int m_sent [N];
  bit rnd_mode = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && bus.req_valid[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_cnt   = 0;
        end
      end
    end else if (bus.req_valid[m_owner] && !bus.tx_full) begin
      m_sent[m_owner]++;
      m_cnt++;
      if (bus.req_last[m_owner] || m_cnt == MB) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  end

  // ---------------- compare process ----------------
  logic [N-1:0] acc;

  always @(negedge clk) begin
    logic [N-1:0] eg;
    logic         ew;
    eg = '0;
    ew = 1'b0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ew = bus.req_valid[m_owner] && !bus.tx_full;
    end
    check("grant", 32'(bus.grant), 32'(eg));
    check("busy", 32'(bus.busy), 32'(m_owner >= 0));
    check("wr_en", 32'(bus.wr_en), 32'(ew));
    check("req_ready", 32'(bus.req_ready), 32'(bus.tx_full ? '0 : eg));
    if (m_owner < 0)
      check("d_in_idle", 32'(bus.d_in), 32'(0));
    else if (rnd_mode)
      check("d_in", 32'(bus.d_in), 32'(byte_val(m_owner, m_sent[m_owner])));
    if (rnd_mode) acc = bus.req_valid & bus.req_ready;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [N-1:0] g, input logic w, input logic [7:0] d);
    @(negedge clk);
    #1;
    check({name, "_grant"}, 32'(bus.grant), 32'(g));
    check({name, "_wr"}, 32'(bus.wr_en), 32'(w));
    if (w) check({name, "_d"}, 32'(bus.d_in), 32'(d));
  endtask

  // ---------------- stimulus ----------------
  int tb_seq [N];
  int rem    [N];
  int full_hold;

  function automatic int new_len();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(17, 30));
    return int'($urandom_range(1, 6));
  endfunction

  initial begin
    bus.req_valid = '1;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_full   = 1'b0;
    #2;
    check("rst_wr", 32'(bus.wr_en), 32'(0));
    check("rst_grant", 32'(bus.grant), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_ready", 32'(bus.req_ready), 32'(0));
    check("rst_d_in", 32'(bus.d_in), 32'(0));
    bus.req_valid = '0;
    @(negedge clk); rst_n = 1'b1;

    // single requester, 3-byte packet
    step(); bus.req_valid[0] = 1'b1; bus.req_data[0] = 8'hA1;
    lit("t1_c0", 4'b0000, 1'b0, 8'h00);
    step(); lit("t1_c1", 4'b0001, 1'b1, 8'hA1);
    step(); bus.req_data[0] = 8'hA2; lit("t1_c2", 4'b0001, 1'b1, 8'hA2);
    step(); bus.req_data[0] = 8'hA3; bus.req_last[0] = 1'b1;
    lit("t1_c3", 4'b0001, 1'b1, 8'hA3);
    step(); bus.req_valid[0] = 1'b0; bus.req_last[0] = 1'b0;
    lit("t1_end", 4'b0000, 1'b0, 8'h00);
    check("t1_model_ptr", 32'(m_ptr), 32'(1));

    // req0 and req2 from reset release
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    step();
    bus.req_valid[0] = 1'b1; bus.req_data[0] = 8'h10;
    bus.req_valid[2] = 1'b1; bus.req_data[2] = 8'h20;
    lit("t2_c0", 4'b0000, 1'b0, 8'h00);
    step(); lit("t2_c1", 4'b0001, 1'b1, 8'h10);
    step(); bus.req_data[0] = 8'h11; bus.req_last[0] = 1'b1;
    lit("t2_c2", 4'b0001, 1'b1, 8'h11);
    step(); bus.req_valid[0] = 1'b0; bus.req_last[0] = 1'b0;
    lit("t2_bubble", 4'b0000, 1'b0, 8'h00);
    step(); lit("t2_c4", 4'b0100, 1'b1, 8'h20);
    step(); bus.req_data[2] = 8'h21; bus.req_last[2] = 1'b1;
    lit("t2_c5", 4'b0100, 1'b1, 8'h21);
    step(); bus.req_valid[2] = 1'b0; bus.req_last[2] = 1'b0;
    lit("t2_end", 4'b0000, 1'b0, 8'h00);
    check("t2_model_ptr", 32'(m_ptr), 32'(3));

    // pointer at 3: req3 before req0
    step();
    bus.req_valid[3] = 1'b1; bus.req_data[3] = 8'h30; bus.req_last[3] = 1'b1;
    bus.req_valid[0] = 1'b1; bus.req_data[0] = 8'h40; bus.req_last[0] = 1'b1;
    step(); lit("t3_first", 4'b1000, 1'b1, 8'h30);
    step(); bus.req_valid[3] = 1'b0; bus.req_last[3] = 1'b0;
    lit("t3_bubble", 4'b0000, 1'b0, 8'h00);
    step(); lit("t3_second", 4'b0001, 1'b1, 8'h40);
    step(); bus.req_valid[0] = 1'b0; bus.req_last[0] = 1'b0;
    lit("t3_end", 4'b0000, 1'b0, 8'h00);

    // back-pressure on req1 mid-packet
    step(); bus.req_valid[1] = 1'b1; bus.req_data[1] = 8'h54;
    step(); lit("t4_b0", 4'b0010, 1'b1, 8'h54);
    step(); bus.req_data[1] = 8'h55; bus.tx_full = 1'b1;
    for (int j = 0; j < 4; j++) begin
      lit("t4_full", 4'b0010, 1'b0, 8'h00);
      check("t4_full_ready", 32'(bus.req_ready), 32'(0));
      if (j < 3) step();
    end
    step(); bus.tx_full = 1'b0; lit("t4_b1", 4'b0010, 1'b1, 8'h55);
    step(); bus.req_data[1] = 8'h56; bus.req_last[1] = 1'b1;
    lit("t4_b2", 4'b0010, 1'b1, 8'h56);
    step(); bus.req_valid[1] = 1'b0; bus.req_last[1] = 1'b0;
    lit("t4_end", 4'b0000, 1'b0, 8'h00);

    // asynchronous reset in the middle of a req2 packet
    step(); bus.req_valid[2] = 1'b1; bus.req_data[2] = 8'h60;
    step(); lit("t5_b0", 4'b0100, 1'b1, 8'h60);
    step(); bus.req_data[2] = 8'h61;
    step(); bus.req_data[2] = 8'h62;
    #2; rst_n = 1'b0;
    #1;
    check("t5_rst_wr", 32'(bus.wr_en), 32'(0));
    check("t5_rst_grant", 32'(bus.grant), 32'(0));
    check("t5_rst_busy", 32'(bus.busy), 32'(0));
    check("t5_rst_d_in", 32'(bus.d_in), 32'(0));
    bus.req_valid[1] = 1'b1; bus.req_data[1] = 8'h70;
    @(negedge clk); rst_n = 1'b1;
    step(); lit("t5_regrant", 4'b0010, 1'b1, 8'h70);
    bus.req_valid = '0;
    bus.req_last  = '0;

    // randomized traffic checked cycle by cycle against the model
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_sent[i] = 0;
      tb_seq[i] = 0;
      rem[i]    = new_len();
    end
    acc       = '0;
    full_hold = 0;
    rnd_mode  = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          tb_seq[i]++;
          rem[i]--;
          if (rem[i] == 0) rem[i] = new_len();
          bus.req_valid[i] = ($urandom_range(0, 9) < 7);
        end else if (!bus.req_valid[i]) begin
          bus.req_valid[i] = 1'($urandom_range(0, 1));
        end
        bus.req_data[i] = byte_val(i, tb_seq[i]);
        bus.req_last[i] = (rem[i] == 1);
      end
      if (full_hold > 0) begin
        bus.tx_full = 1'b1;
        full_hold--;
      end else if ($urandom_range(0, 9) == 0) begin
        bus.tx_full = 1'b1;
        full_hold   = 3;
      end else begin
        bus.tx_full = 1'b0;
      end
    end
    @(negedge clk);
    #1;
    rnd_mode = 1'b0;
    for (int i = 0; i < N; i++) begin
      check($sformatf("bytes_req%0d", i), 32'(tb_seq[i] + 32'(acc[i])), 32'(m_sent[i] + ((m_owner == i && bus.req_valid[i] && !bus.tx_full) ? 1 : 0)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter write port (wr_en/d_in/tx_full of uart_top) among NUM_REQ independent byte-stream requesters.
- Round-robin arbitration with packet lock: a granted requester keeps the port until it sends its last byte or hits a burst cap.
- Sits between the requester logic and uart_top; drives wr_en/d_in directly and obeys tx_full back-pressure.

Parameters:
- NUM_REQ, 4, number of requester channels (2..8).
- DATA_W, 8, byte width; must match uart_top d_in.
- MAX_BURST, 16, maximum bytes per grant before forced rotation (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  input  NUM_REQ  marks the final byte of a packet; qualified by valid.
- req_ready  output  NUM_REQ  per-requester accept.
- wr_en  output  1  write strobe to uart_top.
- d_in  output  DATA_W  byte to uart_top.
- tx_full  input  1  UART TX FIFO full.
- grant  output  NUM_REQ  one-hot current owner; all zero when idle.
- busy  output  1  high while in BURST.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=0, grant=0, burst_cnt=0.
  - wr_en=0, req_ready=0, d_in=0, busy=0.
  - All outputs reach these values immediately, without a clock edge.
- State IDLE:
  - wr_en=0, req_ready=0.
  - If any req_valid is high at a rising edge, select the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register the one-hot grant, clear burst_cnt and go to BURST.
  - No request: stay in IDLE.
- State BURST (owner g):
  - req_ready[g] = !tx_full; all other req_ready bits are 0.
  - wr_en = req_valid[g] & !tx_full (combinational from registered state/grant plus inputs).
  - d_in = req_data[g] while in BURST; 0 otherwise.
  - Transfer = req_valid[g] & req_ready[g]. Each transfer increments burst_cnt.
  - Exit on a transfer with req_last[g]=1, or on the transfer that makes burst_cnt reach MAX_BURST.
  - On exit: next state IDLE, grant=0, rr_ptr=(g+1) mod NUM_REQ.
  - Both exit conditions in the same cycle: single exit, identical result.
  - busy = (state==BURST).
- Latency:
  - A request seen at edge n is granted after edge n.
  - The first wr_en can occur in cycle n+1, i.e. one cycle after the request.
  - There is exactly one idle bubble cycle between consecutive bursts.
- Back-pressure:
  - With tx_full=1, wr_en=0 and req_ready[g]=0.
  - Owner data must be held by the requester; burst_cnt does not advance.
- Valid gaps:
  - The owner may deassert req_valid mid-packet. The grant is held indefinitely with no timeout.
  - Non-owner requests wait.
- Fairness:
  - rr_ptr advances only past the last owner.
  - A requester that is continuously valid is granted within NUM_REQ-1 other bursts.
- req_last on a non-owner is ignored.
- Reset mid-burst: the partial packet is abandoned and no wr_en is issued after reset assertion. Arbitration restarts from index 0.
- Widths:
  - burst_cnt is 8 bits; it is compared against MAX_BURST, never wraps.
  - rr_ptr is $clog2(NUM_REQ) bits with explicit modulo wrap.

Test Plan:
- Only req0 active; sends 0xA1, 0xA2, 0xA3 (last on 0xA3), tx_full=0 -> grant=0001 one cycle after valid; wr_en high 3 consecutive cycles; d_in=A1,A2,A3; then IDLE, rr_ptr=1.
- req0 and req2 both valid from reset release, each a 2-byte packet -> req0 packet first, one bubble cycle, then req2 packet; grant sequence 0001, 0000, 0100.
- tx_full=1 for 4 cycles during req1 mid-packet byte 0x55 -> wr_en=0 and req_ready[1]=0 for those 4 cycles; 0x55 is written exactly once when tx_full drops; no byte lost or duplicated.
- MAX_BURST=16, req3 streams 20 bytes without last while req1 is waiting -> grant released after byte 16; req1 packet is served next; req3 resumes with byte 17.
- rr_ptr=3 with req3 and req0 both valid -> req3 served first, then req0 (pointer wrap 3->0).
- reset asserted asynchronously mid-cycle during req2 byte 2 of 5 -> wr_en, grant and busy go to 0 immediately; after release with req1 and req2 valid, req1 is granted first (pointer=0 scan).
